// File: rtl/rotator_lane_packer_pkg.sv
// Shared types and lane helpers for the rotator-based lane packer.
// Default geometry: 32-bit words made of four 8-bit lanes.
package rotator_lane_packer_pkg;

  localparam int PKG_INPUTWIDTH  = 32;
  localparam int PKG_OUTPUTWIDTH = 2 * PKG_INPUTWIDTH;
  localparam int PKG_SHIFTBITS   = 8;
  localparam int PKG_LANES       = PKG_INPUTWIDTH / PKG_SHIFTBITS;
  localparam int PKG_CNT_W       = $clog2(PKG_LANES + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    EMIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic int lanes(input int width, input int step_bits);
    return width / step_bits;
  endfunction

  // Keeps lanes [count-1:0]; lanes at or above count are forced to zero.
  function automatic logic [PKG_INPUTWIDTH-1:0] lane_mask(input logic [PKG_CNT_W-1:0] count);
    logic [PKG_INPUTWIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < PKG_LANES; i++) begin
      if (i < int'(count)) begin
        mask[i*PKG_SHIFTBITS +: PKG_SHIFTBITS] = {PKG_SHIFTBITS{1'b1}};
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/rotator_lane_packer_rotator.sv
// Lane-granular right rotator: one log2 stage per bit of the rotation amount.
// Rotation amount is counted in lanes of STEP_BITS bits.
module rotator_lane_packer_rotator #(
  parameter int WIDTH     = 64,
  parameter int STEP_BITS = 8,
  parameter int ROT_W     = 3
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [ROT_W-1:0] i_rot,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_stage;

  always_comb begin
    w_stage = i_data;
    for (int s = 0; s < ROT_W; s++) begin
      if (i_rot[s]) begin
        w_stage = (w_stage >> ((1 << s) * STEP_BITS)) |
                  (w_stage << (WIDTH - ((1 << s) * STEP_BITS)));
      end
    end
  end

  assign o_data = w_stage;

endmodule

// File: rtl/rotator_lane_packer.sv
// Packs partially filled input words (LSB-first lanes) into dense output words,
// using a two-word accumulator and a lane rotator to place lanes at the fill point.
module rotator_lane_packer
  import rotator_lane_packer_pkg::*;
#(
  parameter int INPUTWIDTH         = PKG_INPUTWIDTH,
  parameter int OUTPUTWIDTH        = PKG_OUTPUTWIDTH,
  parameter int SHIFTBITS_PER_STEP = PKG_SHIFTBITS,
  localparam int LANES             = lanes(INPUTWIDTH, SHIFTBITS_PER_STEP),
  localparam int CNT_W             = $clog2(LANES + 1),
  localparam int FILL_W            = $clog2(2 * LANES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INPUTWIDTH-1:0] in_data,
  input  logic [CNT_W-1:0]      in_count,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [INPUTWIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    return (int'(c) > LANES) ? CNT_W'(LANES) : c;
  endfunction

  state_t                 r_state;
  logic [OUTPUTWIDTH-1:0] r_acc;
  logic [FILL_W-1:0]      r_fill;
  logic                   r_last_pend;
  logic [INPUTWIDTH-1:0]  r_out_data_p1;
  logic [CNT_W-1:0]       r_out_cnt_p1;
  logic                   r_out_last_p1;
  logic                   r_out_vld_p1;

  logic [CNT_W-1:0]       w_cnt;
  logic [INPUTWIDTH-1:0]  w_masked;
  logic [FILL_W-1:0]      w_rot;
  logic [OUTPUTWIDTH-1:0] w_rot_in;
  logic [OUTPUTWIDTH-1:0] w_rot_out;
  logic [FILL_W-1:0]      w_fill_sum;
  logic                   w_accept;
  logic                   w_slot_free;

  state_t                 w_state_nxt;
  logic [OUTPUTWIDTH-1:0] w_acc_nxt;
  logic [FILL_W-1:0]      w_fill_nxt;
  logic                   w_last_nxt;
  logic                   w_load;
  logic [INPUTWIDTH-1:0]  w_ld_data;
  logic [CNT_W-1:0]       w_ld_cnt;
  logic                   w_ld_last;

  assign in_ready    = (r_state == RUN);
  assign w_accept    = in_valid && in_ready;
  assign w_slot_free = !r_out_vld_p1 || out_ready;

  // Stage p0: mask, zero-extend and rotate the incoming lanes to the fill point.
  always_comb begin
    w_cnt      = sat_count(in_count);
    w_masked   = in_data & lane_mask(w_cnt);
    w_rot_in   = {{(OUTPUTWIDTH-INPUTWIDTH){1'b0}}, w_masked};
    w_rot      = FILL_W'((2 * LANES - int'(r_fill)) % (2 * LANES));
    w_fill_sum = FILL_W'(int'(r_fill) + int'(w_cnt));
  end

  rotator_lane_packer_rotator #(
    .WIDTH     (OUTPUTWIDTH),
    .STEP_BITS (SHIFTBITS_PER_STEP),
    .ROT_W     (FILL_W)
  ) u_rotator (
    .i_data (w_rot_in),
    .i_rot  (w_rot),
    .o_data (w_rot_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_fill_nxt  = r_fill;
    w_last_nxt  = r_last_pend;
    w_load      = 1'b0;
    w_ld_data   = r_acc[INPUTWIDTH-1:0];
    w_ld_cnt    = CNT_W'(LANES);
    w_ld_last   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_accept) begin
          w_acc_nxt  = r_acc | w_rot_out;
          w_fill_nxt = w_fill_sum;
          if (int'(w_fill_sum) >= LANES) begin
            w_state_nxt = EMIT;
            w_last_nxt  = in_last;
          end else if (in_last) begin
            w_state_nxt = FLUSH;
          end
        end
      end
      EMIT: begin
        if (w_slot_free) begin
          w_load     = 1'b1;
          w_ld_last  = r_last_pend && (int'(r_fill) == LANES);
          w_acc_nxt  = r_acc >> INPUTWIDTH;
          w_fill_nxt = FILL_W'(int'(r_fill) - LANES);
          if (r_last_pend && (w_fill_nxt != '0)) begin
            w_state_nxt = FLUSH;
          end else begin
            w_state_nxt = RUN;
            w_last_nxt  = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_ld_cnt    = CNT_W'(r_fill);
          w_ld_last   = 1'b1;
          w_acc_nxt   = '0;
          w_fill_nxt  = '0;
          w_last_nxt  = 1'b0;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Stage p1: accumulator update and registered output slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= RUN;
      r_acc         <= '0;
      r_fill        <= '0;
      r_last_pend   <= 1'b0;
      r_out_data_p1 <= '0;
      r_out_cnt_p1  <= '0;
      r_out_last_p1 <= 1'b0;
      r_out_vld_p1  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_fill      <= w_fill_nxt;
      r_last_pend <= w_last_nxt;
      if (w_load) begin
        r_out_data_p1 <= w_ld_data;
        r_out_cnt_p1  <= w_ld_cnt;
        r_out_last_p1 <= w_ld_last;
        r_out_vld_p1  <= 1'b1;
      end else if (out_ready) begin
        r_out_vld_p1  <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data_p1;
  assign out_count = r_out_cnt_p1;
  assign out_last  = r_out_last_p1;
  assign out_valid = r_out_vld_p1;

endmodule
